// File: rtl/controle_es.sv
// I/O controller: stalls the core for "in" until a debounced button press
// captures the switches; latches "out" values to a display; traps on halt.
module controle_es #(
  parameter int DATA_W   = 32,
  parameter int SW_W     = 16,
  parameter int DEBOUNCE = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              In,
  input  logic              Out,
  input  logic              halt,
  input  logic [DATA_W-1:0] dado_saida,
  input  logic [SW_W-1:0]   chaves,
  input  logic              botao,
  output logic              stall,
  output logic              wr_entrada,
  output logic [DATA_W-1:0] dado_entrada,
  output logic [DATA_W-1:0] display,
  output logic [7:0]        out_cont,
  output logic              aguardando,
  output logic              parado
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {IDLE, ESPERA_IN, GRAVA_IN, HALT} state_t;

  state_t        state;
  logic [1:0]    sync;
  logic          deb;
  logic [CW-1:0] cnt;
  logic          press;

  // Rising edge of the debounced level, seen in the edge where it flips.
  assign press = sync[1] & ~deb & (cnt == CNT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      sync <= '0;
      deb  <= 1'b0;
      cnt  <= '0;
    end else begin
      sync <= {sync[0], botao};
      if (sync[1] != deb) begin
        if (cnt == CNT_LAST) begin
          deb <= sync[1];
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      dado_entrada <= '0;
      display      <= '0;
      out_cont     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (halt)
            state <= HALT;
          else if (In)
            state <= ESPERA_IN;
          else if (Out) begin
            display  <= dado_saida;
            out_cont <= out_cont + 8'd1;
          end
        end
        ESPERA_IN: begin
          if (press) begin
            dado_entrada <= DATA_W'(chaves);
            state        <= GRAVA_IN;
          end
        end
        GRAVA_IN: state <= IDLE;
        HALT:     state <= HALT;
        default:  state <= IDLE;
      endcase
    end
  end

  assign stall      = ((state == IDLE) && (In || halt)) || (state == ESPERA_IN) || (state == HALT);
  assign wr_entrada = (state == GRAVA_IN);
  assign aguardando = (state == ESPERA_IN);
  assign parado     = (state == HALT);

endmodule

// File: tb/tb_controle_es.sv
// Bench for controle_es: directed table, corner-case sequences and a random
// run, all checked against a behavioural model of the I/O controller.
module tb_controle_es;

  localparam int D = 4;

  logic        clock = 1'b0;
  logic        reset, In, Out, halt, botao;
  logic [31:0] dado_saida;
  logic [15:0] chaves;
  logic        stall, wr_entrada, aguardando, parado;
  logic [31:0] dado_entrada, display;
  logic [7:0]  out_cont;

  int n_chk = 0;
  int n_err = 0;

  controle_es #(.DATA_W(32), .SW_W(16), .DEBOUNCE(D)) dut (
    .clock(clock), .reset(reset), .In(In), .Out(Out), .halt(halt),
    .dado_saida(dado_saida), .chaves(chaves), .botao(botao),
    .stall(stall), .wr_entrada(wr_entrada), .dado_entrada(dado_entrada),
    .display(display), .out_cont(out_cont), .aguardando(aguardando), .parado(parado)
  );

  always #5 clock = ~clock;

  // Model: mode of the controller plus a window of the last D synchronized
  // button samples; the debounced level flips once the whole window disagrees.
  localparam int M_IDLE = 0, M_WAIT = 1, M_WRITE = 2, M_HALT = 3;
  int          m_mode;
  bit          m_sh1, m_sh2, m_deb;
  bit          m_win[D];
  logic [31:0] m_din, m_disp;
  logic [7:0]  m_cnt;

  task automatic model_reset();
    m_mode = M_IDLE; m_sh1 = 0; m_sh2 = 0; m_deb = 0;
    for (int i = 0; i < D; i++) m_win[i] = 0;
    m_din = 0; m_disp = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    bit all_diff, pr;
    if (reset) begin
      model_reset();
      return;
    end
    for (int i = D-1; i > 0; i--) m_win[i] = m_win[i-1];
    m_win[0] = m_sh2;
    all_diff = 1;
    for (int i = 0; i < D; i++) if (m_win[i] == m_deb) all_diff = 0;
    pr = all_diff && !m_deb;
    if (all_diff) m_deb = !m_deb;
    m_sh2 = m_sh1; m_sh1 = botao;
    case (m_mode)
      M_IDLE:  if (halt) m_mode = M_HALT;
               else if (In) m_mode = M_WAIT;
               else if (Out) begin m_disp = dado_saida; m_cnt = m_cnt + 8'd1; end
      M_WAIT:  if (pr) begin m_din = {16'h0, chaves}; m_mode = M_WRITE; end
      M_WRITE: m_mode = M_IDLE;
      default: m_mode = M_HALT;
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    bit e_stall;
    e_stall = (m_mode == M_IDLE && (In || halt)) || m_mode == M_WAIT || m_mode == M_HALT;
    chk("stall",        {31'b0, stall},      {31'b0, e_stall});
    chk("wr_entrada",   {31'b0, wr_entrada}, {31'b0, m_mode == M_WRITE});
    chk("aguardando",   {31'b0, aguardando}, {31'b0, m_mode == M_WAIT});
    chk("parado",       {31'b0, parado},     {31'b0, m_mode == M_HALT});
    chk("dado_entrada", dado_entrada, m_din);
    chk("display",      display,      m_disp);
    chk("out_cont",     {24'b0, out_cont}, {24'b0, m_cnt});
  endtask

  // One clock: compare before the edge, advance model with the same inputs.
  task automatic step();
    @(negedge clock);
    cmp_model();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic idle_in();
    reset = 0; In = 0; Out = 0; halt = 0;
  endtask

  typedef struct {
    bit rst, in_f, out_f, halt_f, btn;
    logic [31:0] ds;
    logic [15:0] sw;
    bit e_stall, e_wr, e_ag, e_par;
    logic [31:0] e_disp;
    logic [7:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(bit r, bit i, bit o, bit h, bit b, logic [31:0] ds, logic [15:0] sw,
                              bit es, bit ew, bit ea, bit ep, logic [31:0] ed, logic [7:0] ec);
    vec_t v;
    v.rst = r; v.in_f = i; v.out_f = o; v.halt_f = h; v.btn = b; v.ds = ds; v.sw = sw;
    v.e_stall = es; v.e_wr = ew; v.e_ag = ea; v.e_par = ep; v.e_disp = ed; v.e_cnt = ec;
    return v;
  endfunction

  vec_t tbl[$];
  int   wr_n, stall_n, late_stall;

  initial begin
    reset = 1; In = 0; Out = 0; halt = 0; botao = 0; dado_saida = 0; chaves = 0;
    repeat (2) @(posedge clock);
    model_reset();
    #1;

    // Reset state, Out, halt priority, ignored presses in HALT, reset release, In entry.
    tbl.push_back(mk(0,0,1,0,0, 32'hDEADBEEF,0, 0,0,0,0, 32'h0,        8'd0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,       0, 0,0,0,0, 32'hDEADBEEF, 8'd1));
    tbl.push_back(mk(0,1,1,1,0, 32'h12345678,0, 1,0,0,0, 32'hDEADBEEF, 8'd1));
    for (int i = 0; i < 7; i++)
      tbl.push_back(mk(0,0,1,0,1, 32'h0,     0, 1,0,0,1, 32'hDEADBEEF, 8'd1));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,       0, 1,0,0,1, 32'hDEADBEEF, 8'd1));
    tbl.push_back(mk(1,0,0,0,0, 32'h0,       0, 1,0,0,1, 32'hDEADBEEF, 8'd1));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,       0, 0,0,0,0, 32'h0,        8'd0));
    tbl.push_back(mk(0,1,0,0,0, 32'h0, 16'h00A5, 1,0,0,0, 32'h0,        8'd0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0, 16'h00A5, 1,0,1,0, 32'h0,        8'd0));
    foreach (tbl[k]) begin
      reset = tbl[k].rst; In = tbl[k].in_f; Out = tbl[k].out_f; halt = tbl[k].halt_f;
      botao = tbl[k].btn; dado_saida = tbl[k].ds; chaves = tbl[k].sw;
      #3;
      chk($sformatf("tbl%0d.stall", k), {31'b0, stall},      {31'b0, tbl[k].e_stall});
      chk($sformatf("tbl%0d.wr", k),    {31'b0, wr_entrada}, {31'b0, tbl[k].e_wr});
      chk($sformatf("tbl%0d.ag", k),    {31'b0, aguardando}, {31'b0, tbl[k].e_ag});
      chk($sformatf("tbl%0d.par", k),   {31'b0, parado},     {31'b0, tbl[k].e_par});
      chk($sformatf("tbl%0d.disp", k),  display,             tbl[k].e_disp);
      chk($sformatf("tbl%0d.cnt", k),   {24'b0, out_cont},   {24'b0, tbl[k].e_cnt});
      step();
    end

    // Short glitch while waiting: no press accepted.
    idle_in(); wr_n = 0;
    for (int i = 0; i < 14; i++) begin
      botao = (i < 3);
      #3; wr_n += int'(wr_entrada);
      step();
    end
    chk("glitch.wr_count", wr_n, 0);
    chk("glitch.aguardando", {31'b0, aguardando}, 32'd1);

    // Reset aborts the wait; a later press completes nothing.
    reset = 1; step(); reset = 0; wr_n = 0;
    for (int i = 0; i < 20; i++) begin
      botao = (i < 10);
      #3; wr_n += int'(wr_entrada);
      step();
    end
    chk("abort.wr_count", wr_n, 0);
    chk("abort.dado_entrada", dado_entrada, 32'h0);
    chk("abort.aguardando", {31'b0, aguardando}, 32'd0);

    // Full In: stall holds until the write cycle, exactly one write pulse.
    chaves = 16'h00A5; wr_n = 0; late_stall = 0;
    for (int i = 0; i < 12; i++) begin
      In = (i == 0); botao = (i < 10);
      #3;
      if (wr_n == 0 && !wr_entrada && !stall) late_stall++;
      wr_n += int'(wr_entrada);
      step();
    end
    chk("in.wr_count", wr_n, 1);
    chk("in.stall_gap", late_stall, 0);
    chk("in.dado_entrada", dado_entrada, 32'h000000A5);
    chk("in.aguardando", {31'b0, aguardando}, 32'd0);
    chk("in.stall_after", {31'b0, stall}, 32'd0);

    // Button already debounced high when In arrives: needs release and fresh press.
    idle_in(); chaves = 16'h1234;
    botao = 1; repeat (8) step();
    In = 1; step(); In = 0; wr_n = 0;
    for (int i = 0; i < 10; i++) begin #3; wr_n += int'(wr_entrada); step(); end
    chk("held.wr_count", wr_n, 0);
    chk("held.aguardando", {31'b0, aguardando}, 32'd1);
    botao = 0; repeat (8) step();
    botao = 1;
    for (int i = 0; i < 10; i++) begin #3; wr_n += int'(wr_entrada); step(); end
    chk("fresh.wr_count", wr_n, 1);
    chk("fresh.dado_entrada", dado_entrada, 32'h00001234);
    botao = 0; repeat (8) step();

    // 256 Outs wrap the counter; stall never rises.
    reset = 1; step(); idle_in(); stall_n = 0;
    Out = 1;
    for (int i = 0; i < 256; i++) begin
      dado_saida = 32'hC0DE0000 + i;
      #3; stall_n += int'(stall);
      step();
    end
    Out = 0; #3;
    chk("wrap.out_cont", {24'b0, out_cont}, 32'd0);
    chk("wrap.display", display, 32'hC0DE00FF);
    chk("wrap.stall_count", stall_n, 0);
    step();

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 99) < 2);
      In    = ($urandom_range(0, 99) < 6);
      halt  = ($urandom_range(0, 99) < 1);
      Out   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) botao = ~botao;
      dado_saida = $urandom;
      chaves     = 16'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/controle_es.md
CONTROLE_ES -- requirements
Module: controle_es

Interface
REQ-001 Parameter: DATA_W, default 32, processor word width.
REQ-002 Parameter: SW_W, default 16, switch bank width (SW_W <= DATA_W).
REQ-003 Parameter: DEBOUNCE, default 16, consecutive stable cycles required to accept a button level change (>= 1).
REQ-004 Port: clock  in  1  single system clock; all state updates on rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: In  in  1  decoded "in" instruction flag from the control unit, valid every cycle.
REQ-007 Port: Out  in  1  decoded "out" instruction flag.
REQ-008 Port: halt  in  1  decoded "halt" instruction flag.
REQ-009 Port: dado_saida  in  DATA_W  register-file value to display on Out.
REQ-010 Port: chaves  in  SW_W  user switch bank; asynchronous, sampled only on an accepted press.
REQ-011 Port: botao  in  1  user confirm button; asynchronous, active-high.
REQ-012 Port: stall  out  1  freezes PC and all architectural writes while high.
REQ-013 Port: wr_entrada  out  1  one-cycle register-file write enable for the In result.
REQ-014 Port: dado_entrada  out  DATA_W  captured switch value, zero-extended.
REQ-015 Port: display  out  DATA_W  last value output by an Out instruction.
REQ-016 Port: out_cont  out  8  count of executed Out instructions.
REQ-017 Port: aguardando  out  1  high while waiting for a user press.
REQ-018 Port: parado  out  1  high while halted.

Function
REQ-019 The FSM SHALL have the states IDLE, ESPERA_IN, GRAVA_IN and HALT.
REQ-020 Input priority in IDLE SHALL be halt > In > Out when several flags are high simultaneously.
REQ-021 IDLE + halt SHALL move to HALT; HALT SHALL be left only by reset.
REQ-022 IDLE + In (halt low) SHALL move to ESPERA_IN.
REQ-023 ESPERA_IN SHALL move to GRAVA_IN on an accepted press and capture dado_entrada <= zero-extended chaves in that same edge.
REQ-024 GRAVA_IN SHALL return to IDLE unconditionally after one cycle, without re-sampling In.
REQ-025 IDLE + Out (halt and In low) SHALL, in the same edge, set display <= dado_saida and out_cont <= out_cont+1 (255 wraps to 0); state remains IDLE; no stall.
REQ-026 stall SHALL be combinational: high when (IDLE and (In or halt)) or ESPERA_IN or HALT; low in GRAVA_IN.
REQ-027 wr_entrada SHALL be high only in GRAVA_IN (exactly one cycle per In instruction).
REQ-028 aguardando SHALL equal (state == ESPERA_IN); parado SHALL equal (state == HALT).
REQ-029 botao SHALL pass through a 2-flop synchronizer before any use.
REQ-030 The debounced level SHALL change only after the synchronized level has differed from it for DEBOUNCE consecutive cycles; any mismatch break SHALL clear the stability counter.
REQ-031 An accepted press SHALL be a 0->1 transition of the debounced level; it SHALL be a single-cycle event.
REQ-032 Accepted presses outside ESPERA_IN SHALL be discarded, including one coinciding with the IDLE->ESPERA_IN edge; a button held across entry to ESPERA_IN SHALL NOT complete the In.
REQ-033 display, dado_entrada and out_cont SHALL hold their values except where updated by REQ-023 or REQ-025.

Reset
REQ-034 reset SHALL force state=IDLE, dado_entrada=0, display=0, out_cont=0, synchronizer flops=0, debounced level=0, stability counter=0.
REQ-035 Reset outputs SHALL be stall=0 (unless In/halt is high, per REQ-026), wr_entrada=0, aguardando=0, parado=0.
REQ-036 Reset asserted in ESPERA_IN or HALT SHALL abort the operation with no wr_entrada pulse.

Verification (DEBOUNCE=4)
REQ-037 In=1, chaves=16'h00A5, botao held high 10 cycles -> stall high until GRAVA_IN; single wr_entrada pulse; dado_entrada=32'h000000A5; IDLE afterwards.
REQ-038 In waiting; botao high 3 cycles then low -> no accepted press; aguardando stays 1; wr_entrada stays 0.
REQ-039 Out=1 with dado_saida=32'hDEADBEEF for one cycle -> next cycle display=32'hDEADBEEF, out_cont=1, stall never high; 256 Outs -> out_cont=0.
REQ-040 halt=1 with In=1 and Out=1 -> HALT, parado=1, stall=1, display unchanged; presses ignored; reset -> IDLE with all outputs at reset values.
REQ-041 Reset pulsed in ESPERA_IN, then botao pressed -> no wr_entrada, dado_entrada=0, aguardando=0.
REQ-042 botao already debounced high when In arrives -> no capture until release and a fresh press.
